// File: rtl/osfm_pkg.sv
// Shared widths, types and helpers for the OSFM operand packer.
package osfm_pkg;

    localparam int unsigned OsfmBitwidth  = 8;
    localparam int unsigned OsfmBitwidthI = 6;

    localparam int unsigned OsfmShiftDistance = OsfmBitwidth - OsfmBitwidthI;

    typedef logic [OsfmBitwidth-1:0]  operand_t;
    typedef logic [OsfmBitwidthI-1:0] slice_t;

    typedef struct packed {
        slice_t     slice_a;
        slice_t     slice_b;
        logic [1:0] shift_possible;
    } osfm_pair_t;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/osfm_lowinput_detect.sv
// Combinational low-input detect for one operand: flags pure sign extension above the
// reduced width and selects either the low slice or the MSB-truncated slice.
module osfm_lowinput_detect
    import osfm_pkg::*;
#(
    parameter int unsigned BITWIDTH        = OsfmBitwidth,
    parameter int unsigned OSFM_BITWIDTH_I = OsfmBitwidthI
) (
    input  logic [BITWIDTH-1:0]        op_i,
    output logic                       low_o,
    output logic [OSFM_BITWIDTH_I-1:0] slice_o
);
    localparam int unsigned SHIFTDISTANCE = BITWIDTH - OSFM_BITWIDTH_I;

    logic [SHIFTDISTANCE:0] upper;

    assign upper   = op_i[BITWIDTH-1:OSFM_BITWIDTH_I-1];
    assign low_o   = (&upper) | (~|upper);
    assign slice_o = low_o ? op_i[OSFM_BITWIDTH_I-1:0] : op_i[BITWIDTH-1:SHIFTDISTANCE];

endmodule

// File: rtl/osfm_operand_packer.sv
// Packs signed operand pairs into reduced slices plus shift flags behind a 2-entry FIFO.
// Optional shift statistics counter enabled by macro OSFM_SHIFT_STATS_EN.
module osfm_operand_packer
    import osfm_pkg::*;
#(
    parameter int unsigned BITWIDTH        = OsfmBitwidth,
    parameter int unsigned OSFM_BITWIDTH_I = OsfmBitwidthI,
    parameter int unsigned SHIFTDISTANCE   = OsfmShiftDistance
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITWIDTH-1:0]        op_a,
    input  logic [BITWIDTH-1:0]        op_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OSFM_BITWIDTH_I-1:0] slice_a,
    output logic [OSFM_BITWIDTH_I-1:0] slice_b,
    output logic [1:0]                 shift_possible,
    input  logic                       stat_clr,
    output logic [15:0]                stat_shift_cnt
);
    osfm_pair_t new_pair;
    osfm_pair_t head_q, head_d;
    osfm_pair_t tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, out_valid_q;
    logic       accept, pop;

    osfm_lowinput_detect #(
        .BITWIDTH       (BITWIDTH),
        .OSFM_BITWIDTH_I(OSFM_BITWIDTH_I)
    ) u_detect_a (
        .op_i   (op_a),
        .low_o  (new_pair.shift_possible[0]),
        .slice_o(new_pair.slice_a)
    );

    osfm_lowinput_detect #(
        .BITWIDTH       (BITWIDTH),
        .OSFM_BITWIDTH_I(OSFM_BITWIDTH_I)
    ) u_detect_b (
        .op_i   (op_b),
        .low_o  (new_pair.shift_possible[1]),
        .slice_o(new_pair.slice_b)
    );

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Head register feeds the outputs directly; tail only holds the second entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({accept, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_pair;
                else                 tail_d = new_pair;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Accept needs !full and pop needs non-empty, so occupancy is exactly one here.
            2'b11: head_d = new_pair;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            out_valid_q <= (count_d != 2'd0);
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign slice_a        = head_q.slice_a;
    assign slice_b        = head_q.slice_b;
    assign shift_possible = head_q.shift_possible;

`ifdef OSFM_SHIFT_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + {15'd0, pop2(new_pair.shift_possible)};

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)    cnt_d = 16'd0;
        else if (accept) cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

    assign stat_shift_cnt = cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_shift_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_osfm_operand_packer.sv
// Randomized and directed bench for osfm_operand_packer with a queue-based reference model.
module tb_osfm_operand_packer;
    localparam int BW = 8;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] op_a = '0;
    logic [BW-1:0] op_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] slice_a, slice_b;
    logic [1:0]    shift_possible;
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_shift_cnt;

    int errors = 0;
    int checks = 0;
    int dut_accs = 0;
    int dut_pops = 0;

    typedef struct {
        int sa;
        int sb;
        int sp;
    } exp_pair_t;

    exp_pair_t q[$];
    int        mcnt = 0;

    always #5 clk = ~clk;

    osfm_operand_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .slice_a       (slice_a),
        .slice_b       (slice_b),
        .shift_possible(shift_possible),
        .stat_clr      (stat_clr),
        .stat_shift_cnt(stat_shift_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand fits the reduced signed width iff its value lies in [-32, 31].
    function automatic exp_pair_t model_pack(input logic [BW-1:0] a, input logic [BW-1:0] b);
        exp_pair_t p;
        int va, vb;
        bit la, lb;
        va = int'($signed(a));
        vb = int'($signed(b));
        la = (va >= -32) && (va <= 31);
        lb = (vb >= -32) && (vb <= 31);
        p.sa = la ? (int'(a) % 64) : (int'(a) / 4);
        p.sb = lb ? (int'(b) % 64) : (int'(b) / 4);
        p.sp = (lb ? 2 : 0) + (la ? 1 : 0);
        return p;
    endfunction

    // Reference model: queue of expected pairs, updated on each active edge or reset.
    initial begin
        bit acc, pp;
        exp_pair_t np;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                mcnt = 0;
            end else begin
                acc = in_valid && (q.size() < 2);
                pp  = out_ready && (q.size() > 0);
                np  = model_pack(op_a, op_b);
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(np);
`ifdef OSFM_SHIFT_STATS_EN
                if (stat_clr) mcnt = 0;
                else if (acc) mcnt = ((mcnt + (np.sp & 1) + (np.sp >> 1)) > 65535) ? 65535 :
                                     (mcnt + (np.sp & 1) + (np.sp >> 1));
`endif
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_head", {18'd0, slice_a, slice_b, shift_possible}, 0);
            check("rst_cnt", 32'(stat_shift_cnt), 0);
        end else begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                check("slice_a", 32'(slice_a), q[0].sa);
                check("slice_b", 32'(slice_b), q[0].sb);
                check("shift_possible", 32'(shift_possible), q[0].sp);
            end
            check("stat_cnt", 32'(stat_shift_cnt), mcnt);
            if (in_valid && in_ready) dut_accs++;
            if (out_valid && out_ready) dut_pops++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic r);
        in_valid  = v;
        op_a      = a;
        op_b      = b;
        out_ready = r;
    endtask

    initial begin
        int a0, p0;
        #12 rst_n = 1'b1;
        step();
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);

        // Single accept, one-edge latency.
        drive(1'b1, 8'hF0, 8'h20, 1'b0);
        step();
        check("lat_out_valid", 32'(out_valid), 1);
        check("lit_sa_F0", 32'(slice_a), 32'h30);
        check("lit_sb_20", 32'(slice_b), 32'h08);
        check("lit_sp_01", 32'(shift_possible), 32'h1);
`ifdef OSFM_SHIFT_STATS_EN
        check("lit_cnt1", 32'(stat_shift_cnt), 1);
`endif
        // Fill second entry, then offer a third while stalled.
        drive(1'b1, 8'h00, 8'hFF, 1'b0);
        step();
        check("full_in_ready", 32'(in_ready), 0);
`ifdef OSFM_SHIFT_STATS_EN
        check("lit_cnt3", 32'(stat_shift_cnt), 3);
`endif
        drive(1'b1, 8'h7F, 8'h80, 1'b0);
        step();
        step();
        check("stall_sa", 32'(slice_a), 32'h30);
        check("stall_in_ready", 32'(in_ready), 0);
        // First pop cycle while full: no accept.
        a0 = dut_accs;
        out_ready = 1'b1;
        step();
        check("nopop_accept", 32'(dut_accs - a0), 0);
        check("lit_sa_00", 32'(slice_a), 32'h00);
        check("lit_sb_FF", 32'(slice_b), 32'h3F);
        check("lit_sp_11", 32'(shift_possible), 32'h3);
        step();
        check("lit_sa_7F", 32'(slice_a), 32'h1F);
        check("lit_sb_80", 32'(slice_b), 32'h20);
        check("lit_sp_00", 32'(shift_possible), 32'h0);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        step();
        check("drain_out_valid", 32'(out_valid), 0);

        // Full throughput stream of 10 pairs.
        a0 = dut_accs;
        p0 = dut_pops;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i * 23 + 5), 8'(8'hC0 + i * 7), 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        check("stream_accs", 32'(dut_accs - a0), 10);
        step();
        check("stream_pops", 32'(dut_pops - p0), 10);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [BW-1:0] ra, rb;
            ra = ($urandom_range(0, 1) == 1) ? 8'($signed(6'($urandom))) : 8'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 8'($signed(6'($urandom))) : 8'($urandom);
            drive(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 2) != 0));
            stat_clr = ($urandom_range(0, 40) == 0);
            step();
        end
        stat_clr = 1'b0;

        // Reset with two entries buffered.
        drive(1'b1, 8'h55, 8'h01, 1'b0);
        step();
        step();
        check("pre_rst_full", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_head", {18'd0, slice_a, slice_b, shift_possible}, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid), 0);
        check("post_rst_ready", 32'(in_ready), 1);

`ifdef OSFM_SHIFT_STATS_EN
        // Saturation: zero operands count two shifts each.
        for (int i = 0; i < 32768; i++) begin
            drive(1'b1, 8'h00, 8'h00, 1'b1);
            step();
        end
        check("sat_cnt", 32'(stat_shift_cnt), 32'hFFFF);
        step();
        check("sat_hold", 32'(stat_shift_cnt), 32'hFFFF);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("clr_prio", 32'(stat_shift_cnt), 0);
`else
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("cnt_tied0", 32'(stat_shift_cnt), 0);
`endif
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
